// File: rtl/klp32_ctrl_pkg.sv
// rtl/klp32_ctrl_pkg.sv - shared state encoding and widths for the KLP32 run-control sequencer
package klp32_ctrl_pkg;

  localparam int STATE_W    = 2;
  localparam int STEP_CNT_W = 32;

  typedef enum logic [STATE_W-1:0] {
    S_RST  = 2'd0,
    S_RUN  = 2'd1,
    S_HALT = 2'd2,
    S_STEP = 2'd3
  } run_state_t;

endpackage

// File: rtl/klp32_btn_debounce.sv
// rtl/klp32_btn_debounce.sv - step button synchroniser and debouncer with a one-cycle press pulse
module klp32_btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic reset_in,
  input  logic btnN,
  output logic press
);

  localparam int CNT_W = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);

  logic             syncMeta;
  logic             syncLevel;
  logic             stableLevel;
  logic [CNT_W-1:0] stableCnt;

  // The counter only runs while the synchronised level disagrees with the accepted one,
  // so any bounce back to the accepted level restarts the stability window.
  always_ff @(posedge clk or negedge reset_in) begin
    if (!reset_in) begin
      syncMeta    <= 1'b1;
      syncLevel   <= 1'b1;
      stableLevel <= 1'b1;
      stableCnt   <= '0;
      press       <= 1'b0;
    end else begin
      syncMeta  <= btnN;
      syncLevel <= syncMeta;
      press     <= 1'b0;
      if (syncLevel == stableLevel) begin
        stableCnt <= '0;
      end else if (stableCnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        stableLevel <= syncLevel;
        stableCnt   <= '0;
        press       <= ~syncLevel;
      end else begin
        stableCnt <= stableCnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/klp32_run_ctrl.sv
// rtl/klp32_run_ctrl.sv - KLP32 core clock-enable, reset-hold and run/halt/step sequencer (option: KLP32_BREAKPOINT_EN)
module klp32_run_ctrl
  import klp32_ctrl_pkg::*;
#(
  parameter int TICK_DIV          = 25000000,
  parameter int DEBOUNCE_CYCLES   = 500000,
  parameter int RESET_HOLD_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  reset_in,
  input  logic                  i_mode,
  input  logic                  i_step_n,
  input  logic [31:0]           i_pc,
  input  logic [31:0]           i_bp_addr,
  input  logic                  i_bp_en,
  output logic                  o_core_reset,
  output logic                  o_core_en,
  output logic                  o_halted,
  output logic [STATE_W-1:0]    o_state,
  output logic [STEP_CNT_W-1:0] o_step_count
);

  localparam int TICK_W = $clog2(TICK_DIV);
  localparam int HOLD_W = (RESET_HOLD_CYCLES < 2) ? 1 : $clog2(RESET_HOLD_CYCLES + 1);

  run_state_t            state;
  run_state_t            stateNext;
  logic                  modeMeta;
  logic                  modeSync;
  logic                  press;
  logic [TICK_W-1:0]     tickCnt;
  logic [HOLD_W-1:0]     holdCnt;
  logic [STEP_CNT_W-1:0] stepCount;
  logic                  coreEn;
  logic                  coreReset;
  logic                  halted;
  logic                  tickDue;
  logic                  bpHit;
  logic                  pulse;

  klp32_btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) stepBtn (
    .clk      (clk),
    .reset_in (reset_in),
    .btnN     (i_step_n),
    .press    (press)
  );

  assign tickDue = (tickCnt == TICK_W'(TICK_DIV - 1));

`ifdef KLP32_BREAKPOINT_EN
  logic bpSkip;

  // A resume from halt must get past the instruction it stopped on, so the first
  // free-run pulse after leaving halt ignores the match.
  assign bpHit = i_bp_en && (i_pc == i_bp_addr) && !bpSkip;

  always_ff @(posedge clk or negedge reset_in) begin
    if (!reset_in) begin
      bpSkip <= 1'b0;
    end else if (state == S_HALT && stateNext == S_RUN) begin
      bpSkip <= 1'b1;
    end else if (pulse) begin
      bpSkip <= 1'b0;
    end
  end
`else
  logic unusedBp;

  assign unusedBp = i_bp_en ^ (^i_pc) ^ (^i_bp_addr);
  assign bpHit    = 1'b0;
`endif

  always_comb begin
    stateNext = state;
    pulse     = 1'b0;
    case (state)
      S_RST: begin
        if (holdCnt == HOLD_W'(RESET_HOLD_CYCLES - 1)) begin
          stateNext = modeSync ? S_RUN : S_HALT;
        end
      end
      S_RUN: begin
        if (!modeSync) begin
          stateNext = S_HALT;
        end else if (tickDue) begin
          if (bpHit) stateNext = S_HALT;
          else       pulse     = 1'b1;
        end
      end
      S_HALT: begin
        if (modeSync) begin
          stateNext = S_RUN;
        end else if (press) begin
          stateNext = S_STEP;
          pulse     = 1'b1;
        end
      end
      S_STEP:  stateNext = S_HALT;
      default: stateNext = S_RST;
    endcase
  end

  // Outputs are registered from the next-state decode so they change on the same edge as the state.
  always_ff @(posedge clk or negedge reset_in) begin
    if (!reset_in) begin
      modeMeta  <= 1'b0;
      modeSync  <= 1'b0;
      state     <= S_RST;
      holdCnt   <= '0;
      tickCnt   <= '0;
      stepCount <= '0;
      coreEn    <= 1'b0;
      coreReset <= 1'b1;
      halted    <= 1'b0;
    end else begin
      modeMeta  <= i_mode;
      modeSync  <= modeMeta;
      state     <= stateNext;
      coreEn    <= pulse;
      coreReset <= (stateNext == S_RST);
      halted    <= (stateNext == S_HALT);
      stepCount <= stepCount + STEP_CNT_W'(pulse);
      if (state == S_RST) holdCnt <= holdCnt + HOLD_W'(1);
      if (state != S_RUN && stateNext == S_RUN) begin
        tickCnt <= '0;
      end else if (state == S_RUN) begin
        tickCnt <= tickDue ? '0 : tickCnt + TICK_W'(1);
      end
    end
  end

  assign o_core_reset = coreReset;
  assign o_core_en    = coreEn;
  assign o_halted     = halted;
  assign o_state      = state;
  assign o_step_count = stepCount;

endmodule

// File: tb/tb_klp32_run_ctrl.sv
// tb/tb_klp32_run_ctrl.sv - randomized self-checking bench for klp32_run_ctrl against a behavioural model
module tb_klp32_run_ctrl;

  localparam int TICK = 4;
  localparam int DEB  = 3;
  localparam int HOLD = 2;
  localparam int P_RST = 0, P_RUN = 1, P_HALT = 2, P_STEP = 3;

  logic        clk;
  logic        reset_in;
  logic        i_mode;
  logic        i_step_n;
  logic [31:0] i_pc;
  logic [31:0] i_bp_addr;
  logic        i_bp_en;
  logic        o_core_reset;
  logic        o_core_en;
  logic        o_halted;
  logic [1:0]  o_state;
  logic [31:0] o_step_count;
  logic        preloadEn;

  int nCmp = 0;
  int nBad = 0;

  klp32_run_ctrl #(
    .TICK_DIV(TICK),
    .DEBOUNCE_CYCLES(DEB),
    .RESET_HOLD_CYCLES(HOLD)
  ) dut (
    .clk          (clk),
    .reset_in     (reset_in),
    .i_mode       (i_mode),
    .i_step_n     (i_step_n),
    .i_pc         (i_pc),
    .i_bp_addr    (i_bp_addr),
    .i_bp_en      (i_bp_en),
    .o_core_reset (o_core_reset),
    .o_core_en    (o_core_en),
    .o_halted     (o_halted),
    .o_state      (o_state),
    .o_step_count (o_step_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model: phase, cycles spent in reset hold, ticks since entering run,
  // and the button seen two samples late with a count of consecutive disagreeing samples.
  int          mPhase, mHold, mTick, mRun;
  logic [31:0] mCount;
  logic        mEn, mRst, mHalted, mSkip;
  logic        mModeQ1, mModeQ2, mBtnQ1, mBtnQ2, mStable, mPress;

  always @(posedge clk or negedge reset_in) begin
    if (!reset_in) begin
      mPhase = P_RST; mHold = 0; mTick = 0; mRun = 0;
      mCount = 0; mEn = 0; mRst = 1; mHalted = 0; mSkip = 0;
      mModeQ1 = 0; mModeQ2 = 0; mBtnQ1 = 1; mBtnQ2 = 1; mStable = 1; mPress = 0;
    end else begin
      logic modeNow, pressNow, bpMatch;
      modeNow  = mModeQ2;
      pressNow = mPress;
`ifdef KLP32_BREAKPOINT_EN
      bpMatch = i_bp_en && (i_pc == i_bp_addr) && !mSkip;
`else
      bpMatch = 1'b0;
`endif
      mEn = 0;
      case (mPhase)
        P_RST: begin
          mHold++;
          if (mHold == HOLD) begin
            mPhase = modeNow ? P_RUN : P_HALT;
            mTick  = 0;
          end
        end
        P_RUN: begin
          if (!modeNow) mPhase = P_HALT;
          else begin
            mTick++;
            if (mTick == TICK) begin
              mTick = 0;
              if (bpMatch) mPhase = P_HALT;
              else begin mEn = 1; mCount++; mSkip = 0; end
            end
          end
        end
        P_HALT: begin
          if (modeNow) begin mPhase = P_RUN; mTick = 0; mSkip = 1; end
          else if (pressNow) begin mPhase = P_STEP; mEn = 1; mCount++; mSkip = 0; end
        end
        default: mPhase = P_HALT;
      endcase
      mRst    = (mPhase == P_RST);
      mHalted = (mPhase == P_HALT);
      if (preloadEn) mCount = 32'hFFFF_FFFE;
      mPress = 0;
      if (mBtnQ2 == mStable) mRun = 0;
      else begin
        mRun++;
        if (mRun == DEB) begin mStable = mBtnQ2; mRun = 0; mPress = !mBtnQ2; end
      end
      mBtnQ2 = mBtnQ1; mBtnQ1 = i_step_n;
      mModeQ2 = mModeQ1; mModeQ1 = i_mode;
    end
  end

  task automatic compareModel();
    nCmp++;
    if (o_core_reset !== mRst || o_core_en !== mEn || o_halted !== mHalted ||
        o_state !== 2'(mPhase) || o_step_count !== mCount) begin
      nBad++;
      $display("FAIL cycle t=%0t: got rst=%b en=%b halt=%b st=%0d cnt=%h, want rst=%b en=%b halt=%b st=%0d cnt=%h",
               $time, o_core_reset, o_core_en, o_halted, o_state, o_step_count,
               mRst, mEn, mHalted, mPhase, mCount);
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCmp++;
    if (act !== exp) begin
      nBad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
      compareModel();
      @(negedge clk);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int btnLeft;
    bit seen;
    reset_in = 0; i_mode = 1; i_step_n = 1; i_pc = 0; i_bp_addr = 0; i_bp_en = 0; preloadEn = 0;
    cyc(2);
    chk("rst_core_reset", 32'(o_core_reset), 32'd1);
    chk("rst_core_en", 32'(o_core_en), 32'd0);
    chk("rst_state", 32'(o_state), 32'd0);
    chk("rst_count", o_step_count, 32'd0);
    chk("rst_halted", 32'(o_halted), 32'd0);

    // Release with free-run selected; mode reaches the sequencer two samples late.
    reset_in = 1;
    cyc(1);
    chk("hold_cycle1", 32'(o_core_reset), 32'd1);
    cyc(1);
    chk("hold_done", 32'(o_core_reset), 32'd0);
    cyc(13);
    chk("run_count3", o_step_count, 32'd3);
    chk("run_pulse3", 32'(o_core_en), 32'd1);

    // Mode drops so that the synchronised value is 0 exactly at the next tick.
    cyc(1);
    i_mode = 0;
    cyc(3);
    chk("halt_no_pulse", 32'(o_core_en), 32'd0);
    chk("halt_flag", 32'(o_halted), 32'd1);
    chk("halt_state", 32'(o_state), 32'd2);
    chk("halt_count", o_step_count, 32'd3);

    // Held press gives one step; a single-cycle glitch gives none.
    i_step_n = 0;
    cyc(5);
    i_step_n = 1;
    cyc(1);
    chk("step_pulse", 32'(o_core_en), 32'd1);
    chk("step_state", 32'(o_state), 32'd3);
    chk("step_count", o_step_count, 32'd4);
    cyc(1);
    chk("step_back_halt", 32'(o_state), 32'd2);
    cyc(8);
    i_step_n = 0;
    cyc(1);
    i_step_n = 1;
    cyc(8);
    chk("glitch_count", o_step_count, 32'd4);

    // Counter wrap from a preloaded value.
    preloadEn = 1;
    force dut.stepCount = 32'hFFFF_FFFE;
    cyc(2);
    release dut.stepCount;
    preloadEn = 0;
    cyc(1);
    chk("preload", o_step_count, 32'hFFFF_FFFE);
    i_step_n = 0; cyc(5); i_step_n = 1; cyc(1);
    chk("wrap_ffffffff", o_step_count, 32'hFFFF_FFFF);
    cyc(8);
    i_step_n = 0; cyc(5); i_step_n = 1; cyc(1);
    chk("wrap_zero", o_step_count, 32'h0000_0000);
    chk("wrap_pulse", 32'(o_core_en), 32'd1);
    cyc(1);

`ifdef KLP32_BREAKPOINT_EN
    i_bp_addr = 32'h10; i_pc = 32'h10; i_bp_en = 1; i_mode = 1;
    cyc(11);
    chk("bp_halt_state", 32'(o_state), 32'd2);
    chk("bp_halt_no_pulse", 32'(o_core_en), 32'd0);
    chk("bp_skip_count", o_step_count, 32'd1);
    i_mode = 0;
    cyc(4);
    i_step_n = 0; cyc(5); i_step_n = 1; cyc(1);
    chk("bp_step_pulse", 32'(o_core_en), 32'd1);
    i_bp_en = 0;
    cyc(8);
`endif

    // Asynchronous reset while a pulse is being driven.
    i_mode = 1;
    seen = 0;
    for (int k = 0; k < 30 && !seen; k++) begin
      cyc(1);
      if (o_core_en) seen = 1;
    end
    chk("reset_pulse_found", 32'(seen), 32'd1);
    reset_in = 0;
    #1;
    chk("async_en", 32'(o_core_en), 32'd0);
    chk("async_count", o_step_count, 32'd0);
    chk("async_core_reset", 32'(o_core_reset), 32'd1);
    chk("async_state", 32'(o_state), 32'd0);
    cyc(2);
    reset_in = 1;

    btnLeft = 0;
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 39) == 0) i_mode = ~i_mode;
      if (btnLeft == 0) begin
        i_step_n = ~i_step_n;
        btnLeft  = $urandom_range(1, 6);
      end else begin
        btnLeft--;
      end
      i_pc      = $urandom_range(0, 3);
      i_bp_addr = $urandom_range(0, 3);
      i_bp_en   = 1'($urandom_range(0, 1));
      reset_in  = ($urandom_range(0, 499) == 0) ? 1'b0 : 1'b1;
      cyc(1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end

endmodule

// File: doc/klp32_run_ctrl.md
Name: klp32_run_ctrl

Overview:
Run-control sequencer for the KLP32V1 core on the DE10-Lite board. It produces a slow, single-cycle core enable from the board clock, which replaces the separate slow clock with a clock-enable. It also holds the core in reset after power-up and supports free-run, halt and single-step modes driven by a switch and a push button. It sits in the top level between the board I/O and the processor's clock-enable and reset inputs.

Parameters:
TICK_DIV, 25000000, board-clock cycles per core step in free-run (must be >= 2)
DEBOUNCE_CYCLES, 500000, cycles the synchronised step button must be stable before it is accepted
RESET_HOLD_CYCLES, 16, cycles o_core_reset stays high after reset_in is released

Ports:
clk  input  1  board clock; the only clock
reset_in  input  1  asynchronous, active-low reset (0 = reset)
i_mode  input  1  slide switch: 1 = free-run, 0 = halt/step; asynchronous, synchronised internally
i_step_n  input  1  raw step push button, active-low; synchronised and debounced internally
i_pc  input  32  current core PC (core pcOut)
i_bp_addr  input  32  breakpoint address
i_bp_en  input  1  breakpoint enable
o_core_reset  output  1  active-high reset to the core
o_core_en  output  1  one-cycle core advance pulse
o_halted  output  1  1 while in S_HALT
o_state  output  2  encoded current state
o_step_count  output  32  number of o_core_en pulses issued

Behaviour:
- All flops reset asynchronously on reset_in=0. All outputs are registered.
- Output values during reset: o_core_reset=1, o_core_en=0, o_halted=0, o_step_count=0, state=S_RST.
- i_mode passes through a 2-flop synchroniser. i_step_n passes through a 2-flop synchroniser and then the debouncer. The debouncer emits a 1-cycle press pulse on an accepted high-to-low transition only.
- States (o_state encoding): S_RST=0, S_RUN=1, S_HALT=2, S_STEP=3.
- S_RST: o_core_reset=1 and a hold counter counts to RESET_HOLD_CYCLES.
  - At terminal count: o_core_reset goes to 0 in the same edge, and the block moves to S_RUN if mode_sync=1, else S_HALT.
- S_RUN: a tick counter counts 0..TICK_DIV-1 and wraps. It is cleared on every entry to S_RUN.
  - On the terminal count, o_core_en=1 for exactly one cycle, and o_step_count increments in the same edge.
  - mode_sync=0 takes priority over a coincident tick: no pulse is issued, and the next state is S_HALT.
- S_HALT: o_halted=1 and the tick counter is frozen.
  - A press pulse moves to S_STEP.
  - mode_sync=1 moves to S_RUN. If both occur, S_RUN wins and the press is dropped.
- S_STEP: o_core_en=1 and o_step_count++ for one cycle, then S_HALT unconditionally.
- First cycle of pulse: the pulse is 1 on the first core-clock cycle of the state, so exactly one pulse per entry.
- o_step_count wraps from 0xFFFF_FFFF to 0.
- reset_in asserted mid-operation: immediate return to the reset values. Any in-flight o_core_en is cleared asynchronously.
- A press is ignored in S_RST and S_RUN. Press pulses are not queued.

Optional Feature:
Macro KLP32_BREAKPOINT_EN.
- Defined:
  - In S_RUN, at a tick with i_bp_en=1 and i_pc==i_bp_addr, no pulse is issued and the next state is S_HALT.
  - A bp_skip flag is set on each S_HALT→S_RUN/S_STEP transition. It suppresses the match check for the first pulse after leaving S_HALT, so resuming from a breakpoint advances past it. The flag clears on that pulse.
- Undefined: i_bp_en and i_bp_addr are ignored, and no bp_skip logic is generated. Ports remain.

Decomposition:
- Package klp32_ctrl_pkg:
  - run_state_t enum (2-bit encoding above)
  - STATE_W=2 and STEP_CNT_W=32 constants
- Sub-module klp32_btn_debounce: parameter DEBOUNCE_CYCLES, 2-flop sync, stability counter, press-pulse output; same clk/reset_in.

Test Plan:
All scenarios use TICK_DIV=4, DEBOUNCE_CYCLES=3, RESET_HOLD_CYCLES=2.
1. Release reset_in with i_mode=1 → o_core_reset=1 for 2 cycles, then 0. o_core_en pulses every 4 cycles, and o_step_count reads 1,2,3 after 3 pulses.
2. i_mode=1→0 on the cycle a tick is due → no pulse, o_halted=1, o_state=2, and o_step_count unchanged.
3. In S_HALT, hold i_step_n low for 5 cycles → exactly one o_core_en pulse and count+1; back to S_HALT. A 1-cycle glitch on i_step_n gives no pulse.
4. With KLP32_BREAKPOINT_EN, i_bp_en=1, i_bp_addr=0x10, i_pc=0x10 at a tick → halt with no pulse. One press then gives one pulse (bp_skip). Switching i_mode back to 1 resumes pulses.
5. Assert reset_in mid-S_RUN during the o_core_en high cycle → o_core_en=0 immediately, o_step_count=0, o_core_reset=1.
6. Preload o_step_count near 0xFFFF_FFFF (force), then issue 2 pulses → reads 0xFFFF_FFFF, then 0x0000_0000.
